// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU.
// Results return through a one-entry holding register.
module alu
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    unique case (s)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      3'b101:  result = {{(WIDTH-1){1'b0}}, lt};
      3'b110:  result = a << b;
      default: result = a >> b;
    endcase
  end

  assign zero = (result == '0);

endmodule

module alu_arbiter
#(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_s,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [15:0]      op_count
);

  logic             hold_valid_q, hold_valid_d;
  logic             hold_owner_q, hold_owner_d;
  logic [WIDTH-1:0] hold_result_q, hold_result_d;
  logic             hold_zero_q, hold_zero_d;
  logic             last_grant_q, last_grant_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             can_accept;
  logic             grant;
  logic             fire0, fire1, fire;
  logic             drain;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [2:0]       alu_s;
  logic             alu_zero;

  assign can_accept = !hold_valid_q ||
                      (hold_owner_q ? rsp1_ready : rsp0_ready);

  // Contested grant goes to whoever did not win last time
  assign grant = req1_valid &&
                 (!req0_valid || (!FIXED_PRIO && !last_grant_q));

  assign req0_ready = !rst && can_accept && !grant;
  assign req1_ready = !rst && can_accept && grant;

  assign fire0 = req0_valid && req0_ready;
  assign fire1 = req1_valid && req1_ready;
  assign fire  = fire0 || fire1;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_s = 3'b000;
    unique case (1'b1)
      fire0: begin
        alu_a = req0_a;
        alu_b = req0_b;
        alu_s = req0_s;
      end
      fire1: begin
        alu_a = req1_a;
        alu_b = req1_b;
        alu_s = req1_s;
      end
      default: ;
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .s      (alu_s),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign rsp0_valid = !rst && hold_valid_q && !hold_owner_q;
  assign rsp1_valid = !rst && hold_valid_q && hold_owner_q;
  assign drain      = (rsp0_valid && rsp0_ready) ||
                      (rsp1_valid && rsp1_ready);

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_owner_d  = hold_owner_q;
    hold_result_d = hold_result_q;
    hold_zero_d   = hold_zero_q;
    last_grant_d  = last_grant_q;
    op_count_d    = op_count_q;
    if (fire) begin
      hold_valid_d  = 1'b1;
      hold_owner_d  = fire1;
      hold_result_d = alu_res;
      hold_zero_d   = alu_zero;
      last_grant_d  = fire1;
      op_count_d    = op_count_q + 16'd1;
    end else if (drain) begin
      hold_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q  <= 1'b0;
      hold_owner_q  <= 1'b0;
      hold_result_q <= '0;
      hold_zero_q   <= 1'b0;
      last_grant_q  <= 1'b1;
      op_count_q    <= '0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_owner_q  <= hold_owner_d;
      hold_result_q <= hold_result_d;
      hold_zero_q   <= hold_zero_d;
      last_grant_q  <= last_grant_d;
      op_count_q    <= op_count_d;
    end
  end

  assign rsp_result = hold_result_q;
  assign rsp_zero   = hold_zero_q;
  assign op_count   = op_count_q;

endmodule
